// File: rtl/bus_ram_if.sv
// CPU-to-RAM request strobes and the ready/error response.
// The shared 64-bit data bus stays a separate inout net on bus_ram.
interface bus_ram_if;
    logic [63:0] bus_addr;
    logic        ram_cs;
    logic        ram_we;
    logic        ram_oe;
    logic        ram_ready;
    logic        ram_err;

    modport master (
        output bus_addr, ram_cs, ram_we, ram_oe,
        input  ram_ready, ram_err
    );

    modport slave (
        input  bus_addr, ram_cs, ram_we, ram_oe,
        output ram_ready, ram_err
    );
endinterface

// File: rtl/bus_ram.sv
// Word-organised 64-bit RAM answering CPU bus requests with a registered
// ready/error handshake, programmable wait states and a tristate read return.
module bus_ram #(
    parameter int DEPTH      = 1024,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    bus_ram_if.slave    bus,
    inout  wire  [63:0] bus_data
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_RWAIT, S_WWAIT, S_RDRV, S_WACK, S_ERR, S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   rdata_q;
    logic          rd_q, rd_d;
    logic          rej_q, rej_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;

    logic          mem_we, mem_re;
    logic [AW-1:0] mem_idx;
    logic [63:0]   mem_wdata;
    logic [63:0]   mem [DEPTH];

    logic          req_wr, req_rd, req_bad;
    logic [AW-1:0] req_idx;
    logic          drv_en;
    logic [63:0]   drv_data;

    assign req_wr  = bus.ram_cs & bus.ram_we;
    assign req_rd  = bus.ram_cs & bus.ram_oe & ~bus.ram_we;
    assign req_bad = (bus.bus_addr[2:0] != 3'd0) || (bus.bus_addr[63:3] >= 61'(DEPTH));
    assign req_idx = bus.bus_addr[AW+2:3];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        rej_d     = rej_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_idx   = idx_q;
        mem_wdata = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_wr || req_rd) begin
                    idx_d = req_idx;
                    rd_d  = req_rd;
                    rej_d = req_bad;
                    if (req_wr) begin
                        wdata_d = bus_data;
                        cnt_d   = 3'(WRITE_WAIT);
                    end else begin
                        cnt_d   = 3'(READ_WAIT);
                    end
                    if (req_bad) begin
                        state_d = S_ERR;
                    end else if (req_wr) begin
                        if (WRITE_WAIT == 0) begin
                            mem_we    = 1'b1;
                            mem_idx   = req_idx;
                            mem_wdata = bus_data;
                            state_d   = S_WACK;
                        end else begin
                            state_d   = S_WWAIT;
                        end
                    end else begin
                        if (READ_WAIT == 0) begin
                            mem_re  = 1'b1;
                            mem_idx = req_idx;
                            state_d = S_RDRV;
                        end else begin
                            state_d = S_RWAIT;
                        end
                    end
                end
            end
            // Dropping chip select during a wait abandons the access silently.
            S_RWAIT: begin
                if (!bus.ram_cs) begin
                    cnt_d   = 3'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        mem_re  = 1'b1;
                        state_d = S_RDRV;
                    end
                end
            end
            S_WWAIT: begin
                if (!bus.ram_cs) begin
                    cnt_d   = 3'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        mem_we  = 1'b1;
                        state_d = S_WACK;
                    end
                end
            end
            S_RDRV, S_WACK, S_ERR: state_d = S_HOLD;
            S_HOLD: begin
                if (!bus.ram_cs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_RDRV) || (state_d == S_WACK) || (state_d == S_ERR);
        err_d   = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= '0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            rd_q    <= 1'b0;
            rej_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            rej_q   <= rej_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            if (mem_re) rdata_q <= mem[mem_idx];
        end
    end

    // Array is deliberately unreset; the reset term only blocks commits while held.
    always_ff @(posedge clk) begin
        if (mem_we && reset) mem[mem_idx] <= mem_wdata;
    end

    assign bus.ram_ready = ready_q;
    assign bus.ram_err   = err_q;

    // A rejected read returns zero in ERR, then releases the bus in HOLD.
    assign drv_en = bus.ram_oe & ~bus.ram_we &
                    ((state_q == S_RDRV) ||
                     (state_q == S_ERR  && rd_q) ||
                     (state_q == S_HOLD && rd_q && !rej_q && bus.ram_cs));
    assign drv_data = (state_q == S_ERR) ? 64'd0 : rdata_q;
    assign bus_data = drv_en ? drv_data : {64{1'bz}};

endmodule

// File: tb/tb_bus_ram.sv
// Scoreboard bench for bus_ram: four instances with different wait settings,
// stimulus pushes expected responses, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_bus_ram;
    localparam int NDUT  = 4;
    localparam int DEPTH = 1024;
    localparam int RW [NDUT] = '{1, 0, 3, 7};
    localparam int WW [NDUT] = '{0, 2, 3, 0};

    typedef struct {
        int          sel;
        int          cyc;
        logic        err;
        logic        chk;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] addr, tb_wd;
    logic        cs, we, oe, tb_en;
    int          sel;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          nrdy = 0;
    exp_t        sbq [$];

    logic [NDUT-1:0] rdy, err, oe_v;
    logic [63:0]     rdv [NDUT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        wire [63:0] bd;
        bus_ram_if u_if ();
        assign u_if.bus_addr = addr;
        assign u_if.ram_cs   = cs && (sel == g);
        assign u_if.ram_we   = we;
        assign u_if.ram_oe   = oe;
        assign bd = (tb_en && sel == g) ? tb_wd : {64{1'bz}};
        bus_ram #(.DEPTH(DEPTH), .READ_WAIT(RW[g]), .WRITE_WAIT(WW[g])) u_dut (
            .clk      (clk),
            .reset    (reset),
            .bus      (u_if.slave),
            .bus_data (bd)
        );
        assign rdy[g]  = u_if.ram_ready;
        assign err[g]  = u_if.ram_err;
        assign rdv[g]  = bd;
        assign oe_v[g] = u_dut.drv_en;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (rdy[g]) begin
                nrdy++;
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready: dut%0d got ready=1 expected 0 (cycle %0d)", g, cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("ready_dut", 64'(g), 64'(e.sel));
                    check("latency", 64'(cyc), 64'(e.cyc));
                    check("err", 64'(err[g]), 64'(e.err));
                    if (e.chk) begin
                        check("drive_en", 64'(oe_v[g]), 64'd1);
                        check("rdata", rdv[g], e.data);
                    end
                end
            end else if (err[g]) begin
                check("err_without_ready", 64'(err[g]), 64'd0);
            end
        end
    end

    task automatic idle_bus();
        cs = 1'b0; we = 1'b0; oe = 1'b0; tb_en = 1'b0;
    endtask

    task automatic issue(input int s, input logic [63:0] a, input logic w,
                         input logic [63:0] d, input logic e, input logic [63:0] xd);
        exp_t x;
        int   n;
        @(posedge clk); #1;
        sel = s; addr = a; we = w; oe = !w; tb_wd = d; tb_en = w; cs = 1'b1;
        x.sel  = s;
        x.cyc  = cyc + 1 + (e ? 0 : (w ? WW[s] : RW[s]));
        x.err  = e;
        x.chk  = !w;
        x.data = xd;
        sbq.push_back(x);
        for (n = 0; n < 30; n++) begin
            @(negedge clk);
            if (rdy[s]) break;
        end
        if (n == 30) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: dut%0d addr %h got no ready expected ready", s, a);
            sbq.delete();
        end
        @(posedge clk); #1;
        cs = 1'b0; tb_en = 1'b0;
        @(negedge clk);
        check("bus_released", 64'(oe_v[s]), 64'd0);
        @(posedge clk); #1;
        idle_bus();
    endtask

    initial begin
        int   base;
        logic seen;
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int   base;
        logic seen;
        reset = 1'b0; sel = 0; addr = 64'd0; tb_wd = 64'd0;
        idle_bus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            check("reset_ready", 64'(rdy[g]), 64'd0);
            check("reset_err", 64'(err[g]), 64'd0);
            check("reset_release", 64'(oe_v[g]), 64'd0);
        end
        @(posedge clk); #1 reset = 1'b1;

        // Write then read with default waits.
        issue(0, 64'h40, 1'b1, 64'hDEADBEEF_00000013, 1'b0, 64'd0);
        issue(0, 64'h40, 1'b0, 64'd0, 1'b0, 64'hDEADBEEF_00000013);

        // Wait-state sweep at 0x8.
        for (int g = 0; g < NDUT; g++) begin
            issue(g, 64'h8, 1'b1, 64'hC0DE0000_00000000 | 64'(g * 17 + 5), 1'b0, 64'd0);
            issue(g, 64'h8, 1'b0, 64'd0, 1'b0, 64'hC0DE0000_00000000 | 64'(g * 17 + 5));
        end

        // Rejections: misaligned read, out-of-range writes that would alias word 0.
        issue(0, 64'h0, 1'b1, 64'h01234567_89ABCDEF, 1'b0, 64'd0);
        issue(0, 64'h44, 1'b0, 64'd0, 1'b1, 64'd0);
        issue(0, 64'(DEPTH * 8), 1'b1, 64'hFFFF0000_FFFF0000, 1'b1, 64'd0);
        issue(0, 64'h8000_0000_0000_0000, 1'b1, 64'h55555555_AAAAAAAA, 1'b1, 64'd0);
        issue(0, 64'h0, 1'b0, 64'd0, 1'b0, 64'h01234567_89ABCDEF);

        // Held read: one ready pulse, data driven until chip select drops.
        issue(0, 64'h10, 1'b1, 64'h1111_2222_3333_4444, 1'b0, 64'd0);
        @(posedge clk); #1;
        sel = 0; addr = 64'h10; we = 1'b0; oe = 1'b1; cs = 1'b1;
        begin
            exp_t x;
            x.sel = 0; x.cyc = cyc + 1 + RW[0]; x.err = 1'b0; x.chk = 1'b1;
            x.data = 64'h1111_2222_3333_4444;
            sbq.push_back(x);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy[0]) seen = 1'b1;
            if (seen) begin
                check("held_drive_en", 64'(oe_v[0]), 64'd1);
                check("held_data", rdv[0], 64'h1111_2222_3333_4444);
            end
        end
        check("held_ready_seen", 64'(seen), 64'd1);
        @(posedge clk); #1 cs = 1'b0;
        @(negedge clk);
        check("held_released", 64'(oe_v[0]), 64'd0);
        @(posedge clk); #1 idle_bus();

        // Abort a WRITE_WAIT=3 write after one cycle.
        issue(2, 64'h20, 1'b1, 64'hAAAA_0000_BBBB_0001, 1'b0, 64'd0);
        base = nrdy;
        @(posedge clk); #1;
        sel = 2; addr = 64'h20; we = 1'b1; oe = 1'b0; tb_wd = 64'h9999_9999_9999_9999; tb_en = 1'b1; cs = 1'b1;
        @(posedge clk); #1 idle_bus();
        repeat (6) @(posedge clk);
        #1 check("abort_no_ready", 64'(nrdy), 64'(base));
        issue(2, 64'h20, 1'b0, 64'd0, 1'b0, 64'hAAAA_0000_BBBB_0001);

        // Reset during RWAIT on the READ_WAIT=3 instance.
        issue(2, 64'h28, 1'b1, 64'h0F0F_F0F0_1234_5678, 1'b0, 64'd0);
        base = nrdy;
        @(posedge clk); #1;
        sel = 2; addr = 64'h28; we = 1'b0; oe = 1'b1; cs = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_ready", 64'(rdy[2]), 64'd0);
        check("rst_err", 64'(err[2]), 64'd0);
        check("rst_release", 64'(oe_v[2]), 64'd0);
        idle_bus();
        @(posedge clk); #1 reset = 1'b1;
        check("rst_no_ready", 64'(nrdy), 64'(base));
        issue(2, 64'h28, 1'b0, 64'd0, 1'b0, 64'h0F0F_F0F0_1234_5678);

        repeat (3) @(posedge clk);
        #1 check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_ram.md
# bus_ram

Word-organised RAM that acts as the memory-side responder on the CPU's shared bus (`bus_data`, `bus_addr`, `ram_cs`, `ram_we`, `ram_oe`). It decodes the chip-select/read/write strobes driven by the CPU and performs 64-bit reads and writes. It drives `bus_data` only while returning read data, and it reports completion through a registered ready/error handshake with programmable wait states. The block holds both instruction and data memory for the single-CPU platform.

## Interface
- `DEPTH`, 1024: number of 64-bit words; power of two, at least 2.
- `READ_WAIT`, 1: extra wait cycles before read data is returned, 0–7.
- `WRITE_WAIT`, 0: extra wait cycles before a write is committed, 0–7.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; it clears all control state.
- `bus_data`  inout  64  shared data bus. The block drives it only in the read-return states below and presents `64'bZ` otherwise.
- `bus_addr`  in  64  byte address from the CPU.
- `ram_cs`  in  1  chip select; the request is valid while high.
- `ram_we`  in  1  write strobe; data to write is on `bus_data`.
- `ram_oe`  in  1  read strobe.
- `ram_ready`  out  1  registered; high for exactly one cycle at transaction completion.
- `ram_err`  out  1  registered; high together with `ram_ready` when the access was rejected.

## Operation
- Word index is `bus_addr[63:3]`. An access is rejected if `bus_addr[2:0]` is not 0, or if the index is greater than or equal to `DEPTH`.
- Instructions occupy bits [63:32] of each word, because the IR latches `bus_data[63:32]`. This block does not treat instructions specially.
- Request decode happens in IDLE only:
  - Write request: `ram_cs & ram_we`. Write takes priority over `ram_oe`.
  - Read request: `ram_cs & ram_oe & !ram_we`.
- The FSM has the following states:
  - **IDLE**: samples the request. On a request it latches the address, and for writes also latches `bus_data`. It loads the wait counter with `READ_WAIT` or `WRITE_WAIT`.
    - Rejected request goes to ERR.
    - Read with a counter value of 0 goes to RDRV; otherwise it goes to RWAIT.
    - Write with a counter value of 0 commits the memory write on this same edge and goes to WACK; otherwise it goes to WWAIT.
  - **RWAIT**: decrements the counter. When the counter reaches 1, the next state is RDRV. The memory read happens on the edge that enters RDRV, into a 64-bit read register.
  - **WWAIT**: decrements the counter. On the edge where the counter is 1, it commits the latched data to memory and goes to WACK.
  - **RDRV**: `ram_ready`=1 and the read register is driven onto `bus_data`; next state is HOLD.
  - **WACK** and **ERR**: `ram_ready`=1. ERR also drives `ram_err`=1, and a rejected read also drives `bus_data`=0 in this state. Both go to HOLD.
  - **HOLD**: `ram_ready`=0. For reads, it keeps driving the read register while `ram_cs & ram_oe & !ram_we`. It returns to IDLE on the first cycle with `ram_cs`=0.
- Handshake: the CPU holds `ram_cs` and the strobes until it samples `ram_ready`=1, then drops `ram_cs`. A still-asserted `ram_cs` never starts a second transaction.
- Abort: if `ram_cs` drops while in RWAIT or WWAIT, the block returns to IDLE next edge with no `ram_ready` pulse. A pending write is discarded and never committed.
- Rejected writes never modify memory.
- The memory array is not reset; contents survive `reset`. Reading a never-written word returns an undefined value.
- Bus driver: the `bus_data` drive enable is asserted only when the state is RDRV, HOLD, or ERR-for-read, and `ram_oe & !ram_we` are currently high. It drops combinationally when `ram_oe` falls.

## Timing
- Reset (async, `reset`=0) puts the FSM in IDLE with `ram_ready`=0, `ram_err`=0, `bus_data` released, counter at 0, and the read register at 0. Reset mid-transaction discards any pending write.
- Read latency: a request sampled at edge E0 produces `ram_ready` and valid data in the cycle following edge E0+`READ_WAIT`.
- Write latency: a request sampled at E0 is committed at edge E0+`WRITE_WAIT`, and `ram_ready` is high in the following cycle.
- Error latency: `ram_ready` and `ram_err` are high in the cycle after E0, regardless of the wait parameters.
- Minimum request spacing: a new transaction can begin one cycle after `ram_cs` is seen low in HOLD.
- Read-after-write to the same word returns the new data, once the write's `ram_ready` has been seen.

## Test plan
- Write then read, defaults: write `64'hDEADBEEF_00000013` to address 0x40, then read 0x40. Required response: write `ram_ready` one cycle after the request; read `ram_ready` two cycles after the request with `bus_data` equal to the written value; `bus_data` returns to Z after `ram_cs` drops.
- Wait-state sweep: `READ_WAIT` 0/3/7 and `WRITE_WAIT` 0/2 at address 0x8. Required response: `ram_ready` appears exactly 1+wait cycles after the sampling edge and is high for exactly one cycle.
- Rejections:
  - Read at 0x44 (misaligned): `ram_ready`=`ram_err`=1 one cycle later and `bus_data`=0.
  - Write at `DEPTH`*8: `ram_err`=1, and a later read of word 0 is unchanged.
- Held request: `ram_cs`/`ram_oe` held for 10 cycles at 0x10. Required response: exactly one `ram_ready` pulse, and data driven in every cycle until `ram_cs`=0.
- Abort and reset:
  - `WRITE_WAIT`=3: drop `ram_cs` after 1 cycle; the word is unchanged and there is no `ram_ready`.
  - Assert `reset` during RWAIT: outputs are 0 immediately, `bus_data` is Z, and the next request completes normally.
